// File: rtl/pic_ctrl_seq_n.sv
// Parametrised interrupt controller core: ICW init sequence, OCW decode, IMR/ISR,
// rotating-priority resolver and the two-pulse INTA vector handshake for NUM_IRQ levels.
module pic_ctrl_seq_n #(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_stb,
   input  logic               rd_stb,
   input  logic               a0,
   input  logic [7:0]         din,
   output logic [7:0]         dout,
   input  logic [NUM_IRQ-1:0] irr,
   output logic [NUM_IRQ-1:0] clr_irr,
   input  logic               inta_stb,
   output logic               int_out,
   output logic [7:0]         vec_out,
   output logic               vec_valid,
   output logic [NUM_IRQ-1:0] imr,
   output logic [NUM_IRQ-1:0] isr,
   output logic [7:0]         slave_cfg,
   output logic               init_done
);

   localparam int LOG_N  = $clog2(NUM_IRQ);
   localparam int BANK_W = (LOG_N > 3) ? LOG_N - 3 : 1;
   localparam logic [7:0] HI_MASK = 8'(8'hFF << LOG_N);

   typedef enum logic [2:0] {IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;

   state_t             state, state_n;
   logic [7:0]         icw2;
   logic               ic4, sngl, ltim, upm, aeoi;
   logic               rd_sel, phase, win_vld;
   logic [LOG_N-1:0]   prio_base, win_q;
   logic [BANK_W-1:0]  bank;

   // First set bit of v scanning upward from base (wrapping); MSB flags "found".
   function automatic logic [LOG_N:0] scan(input logic [NUM_IRQ-1:0] v,
                                           input logic [LOG_N-1:0]   base);
      logic [LOG_N:0]   r;
      logic [LOG_N-1:0] idx;
      r = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         idx = base + LOG_N'(i);
         if (v[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   function automatic logic [NUM_IRQ-1:0] onehot(input logic [LOG_N-1:0] l);
      return NUM_IRQ'(1) << l;
   endfunction

   function automatic logic [7:0] byte_at(input logic [NUM_IRQ-1:0] v,
                                          input logic [BANK_W-1:0]  b);
      logic [NUM_IRQ-1:0] s;
      s = v >> {b, 3'b000};
      return s[7:0];
   endfunction

   logic [NUM_IRQ-1:0] eligible, eoi_clr, aeoi_clr, set_mask, isr_n, imr_n;
   logic [LOG_N:0]     win_r, top_r;
   logic               win_found, top_found, req;
   logic [LOG_N-1:0]   win_lvl, top_lvl, win_rank, top_rank, sel_lvl, prio_new;
   logic               prio_upd;
   logic               is_ready, is_icw1, ocw1, ocw2, ocw3, bank_wr;
   logic               inta_ok, inta1, inta2, int_n;
   logic [7:0]         vec_n, rd_byte;

   assign is_ready  = (state == READY);
   assign init_done = is_ready;
   assign is_icw1   = wr_stb & ~a0 & din[4];
   assign ocw1      = is_ready & wr_stb & a0;
   assign ocw2      = is_ready & wr_stb & ~a0 & (din[4:3] == 2'b00);
   assign ocw3      = is_ready & wr_stb & ~a0 & (din[4:3] == 2'b01);
   assign bank_wr   = ocw3 & din[7] & (NUM_IRQ > 8) &
                      (int'(din[BANK_W-1:0]) < NUM_IRQ / 8);
   assign inta_ok   = is_ready & upm & inta_stb & ~is_icw1;
   assign inta1     = inta_ok & ~phase;
   assign inta2     = inta_ok & phase;
   assign sel_lvl   = LOG_N'({bank, din[2:0]});

   assign eligible  = irr & ~imr;
   assign win_r     = scan(eligible, prio_base);
   assign top_r     = scan(isr, prio_base);
   assign win_found = win_r[LOG_N];
   assign win_lvl   = win_r[LOG_N-1:0];
   assign top_found = top_r[LOG_N];
   assign top_lvl   = top_r[LOG_N-1:0];
   // Ranks are distances from prio_base; smaller rank means higher priority.
   assign win_rank  = win_lvl - prio_base;
   assign top_rank  = top_lvl - prio_base;
   assign req       = win_found & (~top_found | (win_rank < top_rank));
   assign int_n     = is_ready & ~is_icw1 & req & ~phase & ~inta1;

   assign vec_n     = (icw2 & HI_MASK) | (8'(win_q) & ~HI_MASK);
   assign rd_byte   = a0 ? byte_at(imr, bank) : byte_at(rd_sel ? isr : irr, bank);
   assign imr_n     = (imr & ~(NUM_IRQ'(8'hFF) << {bank, 3'b000})) |
                      (NUM_IRQ'(din) << {bank, 3'b000});

   always_comb begin
      eoi_clr  = '0;
      prio_upd = 1'b0;
      prio_new = prio_base;
      if (ocw2) begin
         case (din[7:5])
            3'b001, 3'b101: begin
               if (top_found) begin
                  eoi_clr = onehot(top_lvl);
                  if (din[7]) begin
                     prio_upd = 1'b1;
                     prio_new = top_lvl + LOG_N'(1);
                  end
               end
            end
            3'b011, 3'b111: begin
               if (isr != '0) begin
                  eoi_clr = onehot(sel_lvl);
                  if (din[7]) begin
                     prio_upd = 1'b1;
                     prio_new = sel_lvl + LOG_N'(1);
                  end
               end
            end
            3'b110: begin
               prio_upd = 1'b1;
               prio_new = sel_lvl + LOG_N'(1);
            end
            default: ;
         endcase
      end
   end

   // EOI clears are taken from the pre-set ISR so a same-cycle INTA set survives.
   assign set_mask = (inta1 && win_found) ? onehot(win_lvl) : '0;
   assign aeoi_clr = (inta2 && aeoi && win_vld) ? onehot(win_q) : '0;
   assign isr_n    = (isr & ~(eoi_clr | aeoi_clr)) | set_mask;

   always_comb begin
      state_n = state;
      if (is_icw1) begin
         state_n = WAIT_ICW2;
      end else if (wr_stb && a0) begin
         case (state)
            WAIT_ICW2: state_n = !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
            WAIT_ICW3: state_n = ic4 ? WAIT_ICW4 : READY;
            WAIT_ICW4: state_n = READY;
            default:   state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout      <= '0;
         clr_irr   <= '0;
         int_out   <= 1'b0;
         vec_out   <= '0;
         vec_valid <= 1'b0;
         imr       <= '0;
         isr       <= '0;
         slave_cfg <= '0;
         icw2      <= '0;
         ic4       <= 1'b0;
         sngl      <= 1'b0;
         ltim      <= 1'b0;
         upm       <= 1'b0;
         aeoi      <= 1'b0;
         rd_sel    <= 1'b0;
         phase     <= 1'b0;
         win_vld   <= 1'b0;
         win_q     <= '0;
         prio_base <= '0;
         bank      <= '0;
      end else begin
         clr_irr   <= '0;
         vec_valid <= 1'b0;
         int_out   <= int_n;
         if (!is_ready || is_icw1) dout <= '0;
         else if (rd_stb)          dout <= rd_byte;

         if (is_icw1) begin
            ic4       <= din[0];
            sngl      <= din[1];
            ltim      <= din[3];
            upm       <= 1'b0;
            aeoi      <= 1'b0;
            imr       <= '0;
            isr       <= '0;
            prio_base <= '0;
            bank      <= '0;
            rd_sel    <= 1'b0;
            phase     <= 1'b0;
         end else begin
            if (wr_stb && a0) begin
               case (state)
                  WAIT_ICW2: icw2 <= din;
                  WAIT_ICW3: slave_cfg <= din;
                  WAIT_ICW4: begin
                     upm  <= din[0] & ic4;
                     aeoi <= din[1] & ic4;
                  end
                  default: ;
               endcase
            end
            if (ocw1) imr <= imr_n;
            isr <= isr_n;
            if (prio_upd) prio_base <= prio_new;
            if (bank_wr) bank <= din[BANK_W-1:0];
            if (ocw3 && !din[7] && din[1]) rd_sel <= din[0];
            // A spurious first INTA reports the lowest level and leaves the ISR alone.
            if (inta1) begin
               win_q   <= win_found ? win_lvl : LOG_N'(NUM_IRQ - 1);
               win_vld <= win_found;
               phase   <= 1'b1;
               if (win_found && !ltim) clr_irr <= onehot(win_lvl);
            end
            if (inta2) begin
               vec_out   <= vec_n;
               vec_valid <= 1'b1;
               phase     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pic_ctrl_seq_n.sv
// Bench for pic_ctrl_seq_n: an 8-level and a 16-level instance share the host bus;
// vectors are scoreboarded, registers checked directly.
module tb_pic_ctrl_seq_n;

   logic        clk = 1'b0;
   logic        rst, wr_stb, rd_stb, a0, inta_stb;
   logic [7:0]  din;

   logic [7:0]  irr8, clr8, imr8, isr8, dout8, vo8, slave8;
   logic        int8, vv8, init8;
   logic [15:0] irr16, clr16, imr16, isr16;
   logic [7:0]  dout16, vo16, slave16;
   logic        int16, vv16, init16;

   int n_chk = 0;
   int n_err = 0;
   logic [7:0] q8[$];
   logic [7:0] q16[$];
   logic [7:0] d8, d16;

   always #5 clk = ~clk;

   pic_ctrl_seq_n #(.NUM_IRQ(8)) u8 (
      .clk(clk), .rst(rst), .wr_stb(wr_stb), .rd_stb(rd_stb), .a0(a0), .din(din),
      .dout(dout8), .irr(irr8), .clr_irr(clr8), .inta_stb(inta_stb), .int_out(int8),
      .vec_out(vo8), .vec_valid(vv8), .imr(imr8), .isr(isr8), .slave_cfg(slave8),
      .init_done(init8));

   pic_ctrl_seq_n #(.NUM_IRQ(16)) u16 (
      .clk(clk), .rst(rst), .wr_stb(wr_stb), .rd_stb(rd_stb), .a0(a0), .din(din),
      .dout(dout16), .irr(irr16), .clr_irr(clr16), .inta_stb(inta_stb), .int_out(int16),
      .vec_out(vo16), .vec_valid(vv16), .imr(imr16), .isr(isr16), .slave_cfg(slave16),
      .init_done(init16));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (vv8) begin
         if (q8.size() == 0) chk("vec8_unexpected", 64'(vo8), 64'hFFFF);
         else                chk("vec8", 64'(vo8), 64'(q8.pop_front()));
      end
      if (vv16) begin
         if (q16.size() == 0) chk("vec16_unexpected", 64'(vo16), 64'hFFFF);
         else                 chk("vec16", 64'(vo16), 64'(q16.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic a, input logic [7:0] d);
      @(negedge clk);
      a0 = a; din = d; wr_stb = 1'b1;
      @(negedge clk);
      wr_stb = 1'b0;
   endtask

   task automatic rd(input logic a);
      @(negedge clk);
      a0 = a; rd_stb = 1'b1;
      @(negedge clk);
      rd_stb = 1'b0;
      d8 = dout8; d16 = dout16;
   endtask

   task automatic inta1();
      @(negedge clk);
      inta_stb = 1'b1;
      @(negedge clk);
      inta_stb = 1'b0;
   endtask

   task automatic inta2(input logic [7:0] e8, input logic [7:0] e16);
      q8.push_back(e8);
      q16.push_back(e16);
      inta1();
   endtask

   initial begin
      rst = 1'b1; wr_stb = 1'b0; rd_stb = 1'b0; a0 = 1'b0; din = '0;
      inta_stb = 1'b0; irr8 = '0; irr16 = '0;
      tick(3);
      chk("rst_int", 64'(int8), 0);
      chk("rst_init", 64'(init8), 0);
      chk("rst_isr", 64'(isr8), 0);
      chk("rst_imr", 64'(imr8), 0);
      chk("rst_vv", 64'(vv8), 0);
      chk("rst_dout", 64'(dout8), 0);
      chk("rst_clr", 64'(clr16), 0);
      rst = 1'b0;

      // Single, IC4 init: ICW1, ICW2, ICW4.
      wr(1'b0, 8'h13);
      wr(1'b1, 8'h40);
      chk("init_mid", 64'(init8), 0);
      wr(1'b1, 8'h01);
      chk("init_done8", 64'(init8), 1);
      chk("init_done16", 64'(init16), 1);
      chk("init_imr", 64'(imr8), 0);
      chk("init_isr", 64'(isr8), 0);
      chk("init_slave", 64'(slave8), 0);

      // Fixed priority, full INTA, non-specific EOI.
      irr8 = 8'h24; tick(2);
      chk("int_l2", 64'(int8), 1);
      inta1();
      chk("inta1_isr", 64'(isr8), 8'h04);
      chk("inta1_clr", 64'(clr8), 8'h04);
      chk("inta1_int", 64'(int8), 0);
      tick(1);
      chk("clr_pulse", 64'(clr8), 0);
      irr8 = 8'h20;
      inta2(8'h42, 8'h4F);
      chk("vv_hi", 64'(vv8), 1);
      tick(1);
      chk("vv_lo", 64'(vv8), 0);
      chk("nested_int", 64'(int8), 0);
      wr(1'b0, 8'h20);
      chk("eoi_isr", 64'(isr8), 0);
      tick(1);
      chk("int_l5", 64'(int8), 1);
      inta1();
      irr8 = 8'h00;
      inta2(8'h45, 8'h4F);
      chk("isr_l5", 64'(isr8), 8'h20);
      inta1();
      chk("spur_isr1", 64'(isr8), 8'h20);
      inta2(8'h47, 8'h4F);
      chk("spur_isr2", 64'(isr8), 8'h20);

      // Masking and status reads.
      wr(1'b1, 8'h04);
      chk("imr_w", 64'(imr8), 8'h04);
      irr8 = 8'h04; tick(2);
      chk("masked_int", 64'(int8), 0);
      wr(1'b0, 8'h0B);
      rd(1'b0);
      chk("rd_isr", 64'(d8), 8'h20);
      rd(1'b1);
      chk("rd_imr", 64'(d8), 8'h04);
      wr(1'b0, 8'h0A);
      rd(1'b0);
      chk("rd_irr", 64'(d8), 8'h04);
      wr(1'b0, 8'h20);
      wr(1'b1, 8'h00);
      tick(2);
      chk("unmask_int", 64'(int8), 1);
      irr8 = 8'h00; tick(2);

      // Rotation: set priority, rotate on non-specific EOI.
      wr(1'b0, 8'hC5);
      irr8 = 8'h81; tick(2);
      inta1();
      chk("rot_l7", 64'(isr8), 8'h80);
      irr8 = 8'h01;
      inta2(8'h47, 8'h4F);
      wr(1'b0, 8'hA0);
      chk("rot_eoi", 64'(isr8), 0);
      irr8 = 8'h81; tick(2);
      inta1();
      chk("rot_l0", 64'(isr8), 8'h01);
      irr8 = 8'h80;
      inta2(8'h40, 8'h4F);
      wr(1'b0, 8'h20);
      wr(1'b0, 8'hC3);
      irr8 = 8'h91; tick(2);
      inta1();
      chk("setprio_l4", 64'(isr8), 8'h10);
      irr8 = 8'h81;
      inta2(8'h44, 8'h4F);
      wr(1'b0, 8'h20);
      irr8 = 8'h00;
      chk("rot_clean", 64'(isr8), 0);

      // Re-init via ICW3 path, then 16-level banked operation.
      wr(1'b0, 8'h11);
      wr(1'b1, 8'h40);
      chk("icw3_wait", 64'(init8), 0);
      wr(1'b1, 8'h04);
      wr(1'b1, 8'h01);
      chk("icw3_done", 64'(init16), 1);
      chk("slave_cfg", 64'(slave8), 8'h04);
      wr(1'b0, 8'h89);
      wr(1'b1, 8'hFE);
      chk("imr16_bank", 64'(imr16), 16'hFE00);
      chk("imr8_nobank", 64'(imr8), 8'hFE);
      irr16 = 16'h0100; tick(2);
      chk("int16", 64'(int16), 1);
      inta1();
      chk("isr16_l8", 64'(isr16), 16'h0100);
      chk("clr16_l8", 64'(clr16), 16'h0100);
      chk("isr8_spur", 64'(isr8), 0);
      irr16 = 16'h0000;
      inta2(8'h47, 8'h48);
      wr(1'b0, 8'h60);
      chk("seoi16", 64'(isr16), 0);
      rd(1'b1);
      chk("rd16_imr", 64'(d16), 8'hFE);

      // AEOI mode, spurious INTA, reset mid-handshake.
      wr(1'b0, 8'h13);
      wr(1'b1, 8'h40);
      wr(1'b1, 8'h03);
      irr8 = 8'h08; tick(2);
      inta1();
      chk("aeoi_set", 64'(isr8), 8'h08);
      irr8 = 8'h00;
      inta2(8'h43, 8'h4F);
      chk("aeoi_clr", 64'(isr8), 0);
      chk("aeoi_vv", 64'(vv8), 1);
      inta1();
      inta2(8'h47, 8'h4F);
      chk("aeoi_spur", 64'(isr8), 0);
      irr8 = 8'h02; tick(2);
      inta1();
      chk("mid_isr", 64'(isr8), 8'h02);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("mid_init", 64'(init8), 0);
      chk("mid_isr0", 64'(isr8), 0);
      chk("mid_vv", 64'(vv8), 0);
      chk("mid_int", 64'(int8), 0);
      inta1();
      chk("idle_vv", 64'(vv8), 0);
      irr8 = 8'h00;
      tick(2);

      chk("q8_drained", 64'(q8.size()), 0);
      chk("q16_drained", 64'(q16.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
